move_path_checker: RTL and testbench
====================================

Name: move_path_checker

Overview:
- Parametrised successor to the chess move-rule logic.
- Validates one requested move (src to dst) against a flattened board of any rows x cols size.
- Sliding pieces (rook, bishop, queen) are checked for blocking pieces by a sequential square-by-square walk.
- Sits between the cursor/selection FSM and the board RAM writer; the selection FSM issues a request and waits for done before committing the move.

Parameters:
- ROW_BITS, 3, log2 of board rows (rows = 2^ROW_BITS).
- COL_BITS, 3, log2 of board columns (cols = 2^COL_BITS).
- PIECE_W, 4, bits per square: MSB is colour (0 white, 1 black), low 3 bits are type.
- Derived, not overridable: AW = ROW_BITS+COL_BITS; SQUARES = 2^AW; BOARD_W = PIECE_W*SQUARES.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- req  in  1  start check; sampled only in IDLE
- src_address  in  AW  source square {row,col}; latched on accepted req
- dst_address  in  AW  destination square {row,col}; latched on accepted req
- player  in  1  side to move; latched on accepted req
- passed_board  in  BOARD_W  square i at bits [PIECE_W*i +: PIECE_W]; must be held stable while busy
- busy  out  1  high from the cycle after req acceptance until done
- done  out  1  one-cycle pulse, result available
- is_valid_move  out  1  result; valid while done=1, holds its value until the next done
- blocked_address  out  AW  first occupied square found in path; meaningful only when done=1, is_valid_move=0, and the cause is blocking

Behaviour:
- Piece codes: EMPTY 0, PAWN 1, BISHOP 2, KNIGHT 3, ROOK 4, QUEEN 5, KING 6. Codes 7+ are invalid.
- Reset (async, any state): state goes to IDLE; busy=0, done=0, is_valid_move=0, blocked_address=0.
- States:
  - IDLE: req=1 latches src/dst/player, goes to DECODE.
  - DECODE: one cycle. Computes |dr|, |dc| as unsigned AW-wide, plus step signs. Applies the rule checks below. Goes to WALK if the move needs a path walk and has at least one intermediate square; otherwise goes to RESULT.
  - WALK: each cycle advances walk pointer by (sr,sc) ∈ {-1,0,+1}² and reads that square.
    - Occupied: record it in blocked_address, fail, go to RESULT.
    - Pointer + step == dst: pass, go to RESULT.
  - RESULT: done=1 and is_valid_move driven for one cycle; busy=0; next state IDLE.
- Rule checks. Any failure goes straight to RESULT with is_valid_move=0:
  - src==dst.
  - src is empty or not player's colour.
  - dst holds a player-colour non-empty piece.
  - Invalid piece code.
- Geometry:
  - Knight: (|dr|,|dc|) ∈ {(1,2),(2,1)}.
  - King: max(|dr|,|dc|)=1.
  - Rook: dr=0 or dc=0.
  - Bishop: |dr|=|dc|.
  - Queen: rook or bishop geometry.
- Pawn:
  - White moves to decreasing row; black to increasing row.
  - Single step requires dst empty.
  - Double step requires start row (white rows-2, black 1), dst empty, and the middle square empty. The middle square is checked in DECODE; no walk.
  - Diagonal one-step requires dst to hold an opponent piece.
- Latency: req sampled at edge T, done high during the cycle after edge T+2+k. k = number of intermediate squares walked (k=0 for non-sliders or adjacent moves). Maximum k = max(rows,cols)-2.
- req while busy or in RESULT is ignored, not queued.
- Board edges: addresses never wrap. Geometry is computed from the row/col fields separately, so col 7 to col 0 of the next row is dc=7, not 1.
- Reset mid-WALK: abandons the check; no done pulse.

Optional Feature:
- Macro: MOVE_PATH_CHECK_EN.
- Defined: WALK state exists and sliding pieces are rejected when blocked; blocked_address is reported.
- Undefined: WALK is not synthesised. Sliding pieces pass on geometry plus destination-colour checks only (legacy rule), done always at T+2, and blocked_address is tied to 0.

Test Plan (8x8 board, addr = row*8+col, MOVE_PATH_CHECK_EN defined):
- White rook at 56, squares 48/40 empty, req 56->32, player 0 -> busy for 4 cycles; done at T+4; is_valid_move=1.
- Same board with a black pawn at 48, req 56->32 -> done at T+3; is_valid_move=0; blocked_address=48.
- White pawn at 52, 44 and 36 empty, req 52->36 -> valid at T+2. With 44 occupied -> invalid at T+2.
- Black knight at 1, white piece at 18, player 1, req 1->18 -> valid at T+2. Same request with player 0 -> invalid.
- Queen walk 63->0 on an empty diagonal, with req re-pulsed mid-walk -> one done at T+8, valid, second req ignored.
- rst asserted during WALK of the rook case -> busy=0 and done=0 immediately. A fresh req after rst release completes normally.

Source files
------------

// File: rtl/move_path_checker.sv
// move_path_checker: validates one requested chess move (src -> dst) on a flattened
// 2^ROW_BITS x 2^COL_BITS board. Rule and geometry checks take one DECODE cycle.
// Optional macro MOVE_PATH_CHECK_EN: adds a WALK state that steps square by square
// along rook/bishop/queen paths, rejects blocked moves and reports the first blocker.
// With the macro undefined, sliders pass on geometry and destination colour only,
// and blocked_address is tied to zero.
module move_path_checker #(
    parameter int unsigned ROW_BITS = 3,
    parameter int unsigned COL_BITS = 3,
    parameter int unsigned PIECE_W  = 4
) (
    input  logic                                           clk,
    input  logic                                           rst,
    input  logic                                           req,
    input  logic [ROW_BITS+COL_BITS-1:0]                   src_address,
    input  logic [ROW_BITS+COL_BITS-1:0]                   dst_address,
    input  logic                                           player,
    input  logic [PIECE_W*(1<<(ROW_BITS+COL_BITS))-1:0]    passed_board,
    output logic                                           busy,
    output logic                                           done,
    output logic                                           is_valid_move,
    output logic [ROW_BITS+COL_BITS-1:0]                   blocked_address
);

    localparam int unsigned AW      = ROW_BITS + COL_BITS;
    localparam int unsigned SQUARES = 1 << AW;
    localparam int unsigned ROWS    = 1 << ROW_BITS;

    localparam logic [2:0] EMPTY  = 3'd0;
    localparam logic [2:0] PAWN   = 3'd1;
    localparam logic [2:0] BISHOP = 3'd2;
    localparam logic [2:0] KNIGHT = 3'd3;
    localparam logic [2:0] ROOK   = 3'd4;
    localparam logic [2:0] QUEEN  = 3'd5;
    localparam logic [2:0] KING   = 3'd6;

    localparam logic [AW-1:0]       D_ZERO      = '0;
    localparam logic [AW-1:0]       D_ONE       = AW'(1);
    localparam logic [AW-1:0]       D_TWO       = AW'(2);
    localparam logic [ROW_BITS-1:0] ROW_ONE     = ROW_BITS'(1);
    localparam logic [ROW_BITS-1:0] WHITE_START = ROW_BITS'(ROWS - 2);

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StDecode = 2'd1,
`ifdef MOVE_PATH_CHECK_EN
        StWalk   = 2'd2,
`endif
        StResult = 2'd3
    } state_e;

    state_e          r_state;
    logic [AW-1:0]   r_src;
    logic [AW-1:0]   r_dst;
    logic            r_player;
    logic            r_busy;
    logic            r_done;
    logic            r_valid;
    logic            r_pass;

    // Unpacked view of the board, one entry per square.
    logic [PIECE_W-1:0] w_sq [SQUARES];
    for (genvar gi = 0; gi < SQUARES; gi++) begin : g_sq
        assign w_sq[gi] = passed_board[PIECE_W*gi +: PIECE_W];
    end

    logic [ROW_BITS-1:0] w_src_row, w_dst_row, w_mid_row, w_dr_raw;
    logic [COL_BITS-1:0] w_src_col, w_dst_col, w_dc_raw;
    logic [AW-1:0]       w_dr, w_dc;
    logic [PIECE_W-1:0]  w_src_piece, w_dst_piece;
    logic [2:0]          w_src_type, w_dst_type;
    logic                w_dst_empty, w_mid_empty, w_fwd, w_pawn_start;

    assign w_src_row   = r_src[AW-1:COL_BITS];
    assign w_src_col   = r_src[COL_BITS-1:0];
    assign w_dst_row   = r_dst[AW-1:COL_BITS];
    assign w_dst_col   = r_dst[COL_BITS-1:0];
    assign w_src_piece = w_sq[r_src];
    assign w_dst_piece = w_sq[r_dst];
    assign w_src_type  = w_src_piece[2:0];
    assign w_dst_type  = w_dst_piece[2:0];
    assign w_dst_empty = (w_dst_type == EMPTY);

    // Row and column distances are taken separately so addresses never wrap across rows.
    assign w_dr_raw = (w_dst_row >= w_src_row) ? (w_dst_row - w_src_row)
                                               : (w_src_row - w_dst_row);
    assign w_dc_raw = (w_dst_col >= w_src_col) ? (w_dst_col - w_src_col)
                                               : (w_src_col - w_dst_col);
    assign w_dr     = {{COL_BITS{1'b0}}, w_dr_raw};
    assign w_dc     = {{ROW_BITS{1'b0}}, w_dc_raw};

    // White pawns advance toward row 0, black pawns toward the last row.
    assign w_fwd        = r_player ? (w_dst_row > w_src_row) : (w_dst_row < w_src_row);
    assign w_mid_row    = r_player ? (w_src_row + ROW_ONE) : (w_src_row - ROW_ONE);
    assign w_mid_empty  = (w_sq[{w_mid_row, w_src_col}][2:0] == EMPTY);
    assign w_pawn_start = (w_src_row == (r_player ? ROW_ONE : WHITE_START));

    logic w_straight, w_diag, w_geom_ok, w_slider, w_rule_ok;

    assign w_straight = (w_dr == D_ZERO) || (w_dc == D_ZERO);
    assign w_diag     = (w_dr == w_dc);

    // Per-piece geometry; w_slider marks pieces whose path may need walking.
    always_comb begin
        w_geom_ok = 1'b0;
        w_slider  = 1'b0;
        case (w_src_type)
            PAWN: begin
                w_geom_ok = (w_fwd && w_dc == D_ZERO && w_dr == D_ONE && w_dst_empty) ||
                            (w_fwd && w_dc == D_ZERO && w_dr == D_TWO && w_dst_empty &&
                             w_pawn_start && w_mid_empty) ||
                            (w_fwd && w_dc == D_ONE && w_dr == D_ONE && !w_dst_empty);
            end
            BISHOP: begin
                w_geom_ok = w_diag;
                w_slider  = 1'b1;
            end
            KNIGHT: begin
                w_geom_ok = (w_dr == D_ONE && w_dc == D_TWO) || (w_dr == D_TWO && w_dc == D_ONE);
            end
            ROOK: begin
                w_geom_ok = w_straight;
                w_slider  = 1'b1;
            end
            QUEEN: begin
                w_geom_ok = w_straight || w_diag;
                w_slider  = 1'b1;
            end
            KING: begin
                w_geom_ok = (w_dr <= D_ONE) && (w_dc <= D_ONE);
            end
            default: begin
                w_geom_ok = 1'b0;
            end
        endcase
    end

    // Ownership, emptiness and code checks combined with the geometry result.
    assign w_rule_ok = (r_src != r_dst) &&
                       (w_src_type != EMPTY) && (w_src_piece[PIECE_W-1] == r_player) &&
                       !(!w_dst_empty && (w_dst_piece[PIECE_W-1] == r_player)) &&
                       (w_src_type != 3'd7) && (w_dst_type != 3'd7) &&
                       w_geom_ok;

`ifdef MOVE_PATH_CHECK_EN
    localparam logic [COL_BITS-1:0] COL_ONE = COL_BITS'(1);

    logic [ROW_BITS-1:0] r_ptr_row, w_next_row, w_after_row;
    logic [COL_BITS-1:0] r_ptr_col, w_next_col, w_after_col;
    logic [AW-1:0]       r_blocked, w_next_addr, w_after_addr, w_dmax;
    logic                r_row_mv, r_row_neg, r_col_mv, r_col_neg;
    logic                w_need_walk, w_next_occupied;

    assign w_dmax      = (w_dr > w_dc) ? w_dr : w_dc;
    assign w_need_walk = w_rule_ok && w_slider && (w_dmax > D_ONE);

    assign w_next_row  = !r_row_mv ? r_ptr_row :
                         (r_row_neg ? (r_ptr_row - ROW_ONE) : (r_ptr_row + ROW_ONE));
    assign w_next_col  = !r_col_mv ? r_ptr_col :
                         (r_col_neg ? (r_ptr_col - COL_ONE) : (r_ptr_col + COL_ONE));
    assign w_after_row = !r_row_mv ? w_next_row :
                         (r_row_neg ? (w_next_row - ROW_ONE) : (w_next_row + ROW_ONE));
    assign w_after_col = !r_col_mv ? w_next_col :
                         (r_col_neg ? (w_next_col - COL_ONE) : (w_next_col + COL_ONE));
    assign w_next_addr     = {w_next_row, w_next_col};
    assign w_after_addr    = {w_after_row, w_after_col};
    assign w_next_occupied = (w_sq[w_next_addr][2:0] != EMPTY);

    assign blocked_address = r_blocked;
`else
    assign blocked_address = '0;
`endif

    // Control FSM with registered busy/done/result outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= StIdle;
            r_src    <= '0;
            r_dst    <= '0;
            r_player <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_valid  <= 1'b0;
            r_pass   <= 1'b0;
`ifdef MOVE_PATH_CHECK_EN
            r_ptr_row <= '0;
            r_ptr_col <= '0;
            r_row_mv  <= 1'b0;
            r_row_neg <= 1'b0;
            r_col_mv  <= 1'b0;
            r_col_neg <= 1'b0;
            r_blocked <= '0;
`endif
        end else begin
            r_done <= 1'b0;
            case (r_state)
                StIdle: begin
                    if (req) begin
                        r_src    <= src_address;
                        r_dst    <= dst_address;
                        r_player <= player;
                        r_busy   <= 1'b1;
                        r_state  <= StDecode;
                    end
                end
                StDecode: begin
`ifdef MOVE_PATH_CHECK_EN
                    if (w_need_walk) begin
                        r_ptr_row <= w_src_row;
                        r_ptr_col <= w_src_col;
                        r_row_mv  <= (w_dst_row != w_src_row);
                        r_row_neg <= (w_dst_row < w_src_row);
                        r_col_mv  <= (w_dst_col != w_src_col);
                        r_col_neg <= (w_dst_col < w_src_col);
                        r_state   <= StWalk;
                    end else begin
                        r_pass  <= w_rule_ok;
                        r_state <= StResult;
                    end
`else
                    r_pass  <= w_rule_ok;
                    r_state <= StResult;
`endif
                end
`ifdef MOVE_PATH_CHECK_EN
                StWalk: begin
                    if (w_next_occupied) begin
                        r_blocked <= w_next_addr;
                        r_pass    <= 1'b0;
                        r_state   <= StResult;
                    end else if (w_after_addr == r_dst) begin
                        r_pass  <= 1'b1;
                        r_state <= StResult;
                    end else begin
                        r_ptr_row <= w_next_row;
                        r_ptr_col <= w_next_col;
                    end
                end
`endif
                StResult: begin
                    r_done  <= 1'b1;
                    r_busy  <= 1'b0;
                    r_valid <= r_pass;
                    r_state <= StIdle;
                end
                default: begin
                    r_state <= StIdle;
                end
            endcase
        end
    end

    assign busy          = r_busy;
    assign done          = r_done;
    assign is_valid_move = r_valid;

endmodule

// File: tb/tb_move_path_checker.sv
// Directed bench for move_path_checker on the default 8x8 board (addr = row*8+col).
// Expected latencies follow MOVE_PATH_CHECK_EN when it is defined for the build.
module tb_move_path_checker;

`ifdef MOVE_PATH_CHECK_EN
    localparam bit WALK_EN = 1'b1;
`else
    localparam bit WALK_EN = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         req = 1'b0;
    logic [5:0]   src_address = '0;
    logic [5:0]   dst_address = '0;
    logic         player = 1'b0;
    logic [255:0] passed_board = '0;
    logic         busy, done, is_valid_move;
    logic [5:0]   blocked_address;

    int n_vec = 0;
    int n_err = 0;

    move_path_checker dut (
        .clk             (clk),
        .rst             (rst),
        .req             (req),
        .src_address     (src_address),
        .dst_address     (dst_address),
        .player          (player),
        .passed_board    (passed_board),
        .busy            (busy),
        .done            (done),
        .is_valid_move   (is_valid_move),
        .blocked_address (blocked_address)
    );

    always #5 clk = ~clk;

    task automatic put(input int idx, input logic [3:0] code);
        passed_board[4*idx +: 4] = code;
    endtask

    // Issue one request; lat counts negedges after the accepting edge until done (-1: none).
    task automatic run_move(input logic [5:0] s, input logic [5:0] d, input logic p,
                            output int lat, output logic vld, output logic [5:0] blk,
                            output int busy_cyc);
        @(negedge clk);
        src_address = s;
        dst_address = d;
        player      = p;
        req         = 1'b1;
        @(negedge clk);
        req      = 1'b0;
        lat      = -1;
        vld      = 1'b0;
        blk      = '0;
        busy_cyc = 0;
        for (int n = 0; n < 40; n++) begin
            if (done) begin
                lat = n;
                vld = is_valid_move;
                blk = blocked_address;
                break;
            end
            if (busy) busy_cyc++;
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_vec++; if (done !== 1'b0) begin n_err++; $display("FAIL reset_done: got %b want 0", done); end
        n_vec++; if (is_valid_move !== 1'b0) begin
            n_err++; $display("FAIL reset_valid: got %b want 0", is_valid_move);
        end
        n_vec++; if (blocked_address !== 6'd0) begin
            n_err++; $display("FAIL reset_blocked: got %0d want 0", blocked_address);
        end
        rst = 1'b0;
    endtask

    task automatic test_rook_walk();
        int lat, bc; logic v; logic [5:0] b;
        passed_board = '0;
        put(56, 4'h4);
        run_move(6'd56, 6'd32, 1'b0, lat, v, b, bc);
        n_vec++; if (lat != (WALK_EN ? 4 : 2)) begin
            n_err++; $display("FAIL rook_clear_lat: got %0d want %0d", lat, WALK_EN ? 4 : 2);
        end
        n_vec++; if (v !== 1'b1) begin n_err++; $display("FAIL rook_clear_valid: got %b want 1", v); end
        n_vec++; if (bc != (WALK_EN ? 4 : 2)) begin
            n_err++; $display("FAIL rook_clear_busy: got %0d want %0d", bc, WALK_EN ? 4 : 2);
        end
        put(48, 4'h9);
        run_move(6'd56, 6'd32, 1'b0, lat, v, b, bc);
        n_vec++; if (lat != (WALK_EN ? 3 : 2)) begin
            n_err++; $display("FAIL rook_blk_lat: got %0d want %0d", lat, WALK_EN ? 3 : 2);
        end
        n_vec++; if (v !== !WALK_EN) begin
            n_err++; $display("FAIL rook_blk_valid: got %b want %b", v, !WALK_EN);
        end
        n_vec++; if (b !== (WALK_EN ? 6'd48 : 6'd0)) begin
            n_err++; $display("FAIL rook_blk_addr: got %0d want %0d", b, WALK_EN ? 48 : 0);
        end
        // Adjacent slider move has no intermediate square.
        passed_board = '0;
        put(56, 4'h4);
        run_move(6'd56, 6'd48, 1'b0, lat, v, b, bc);
        n_vec++; if (lat != 2) begin n_err++; $display("FAIL rook_adj_lat: got %0d want 2", lat); end
        n_vec++; if (v !== 1'b1) begin n_err++; $display("FAIL rook_adj_valid: got %b want 1", v); end
    endtask

    task automatic test_pawn();
        int lat, bc; logic v; logic [5:0] b;
        passed_board = '0;
        put(52, 4'h1);
        run_move(6'd52, 6'd36, 1'b0, lat, v, b, bc);
        n_vec++; if (lat != 2) begin n_err++; $display("FAIL pawn_dbl_lat: got %0d want 2", lat); end
        n_vec++; if (v !== 1'b1) begin n_err++; $display("FAIL pawn_dbl_valid: got %b want 1", v); end
        repeat (3) @(negedge clk);
        n_vec++; if (is_valid_move !== 1'b1) begin
            n_err++; $display("FAIL valid_hold: got %b want 1", is_valid_move);
        end
        put(44, 4'h9);
        run_move(6'd52, 6'd36, 1'b0, lat, v, b, bc);
        n_vec++; if (lat != 2) begin n_err++; $display("FAIL pawn_mid_lat: got %0d want 2", lat); end
        n_vec++; if (v !== 1'b0) begin n_err++; $display("FAIL pawn_mid_valid: got %b want 0", v); end
        passed_board = '0;
        put(9, 4'h9);
        run_move(6'd9, 6'd25, 1'b1, lat, v, b, bc);
        n_vec++; if (v !== 1'b1 || lat != 2) begin
            n_err++; $display("FAIL pawn_black_dbl: got valid %b lat %0d want 1 lat 2", v, lat);
        end
    endtask

    task automatic test_knight();
        int lat, bc; logic v; logic [5:0] b;
        passed_board = '0;
        put(1, 4'hB);
        put(18, 4'h2);
        run_move(6'd1, 6'd18, 1'b1, lat, v, b, bc);
        n_vec++; if (lat != 2) begin n_err++; $display("FAIL knight_lat: got %0d want 2", lat); end
        n_vec++; if (v !== 1'b1) begin n_err++; $display("FAIL knight_valid: got %b want 1", v); end
        run_move(6'd1, 6'd18, 1'b0, lat, v, b, bc);
        n_vec++; if (v !== 1'b0) begin n_err++; $display("FAIL knight_wrong_side: got %b want 0", v); end
    endtask

    task automatic test_edges();
        int lat, bc; logic v; logic [5:0] b;
        passed_board = '0;
        put(7, 4'h6);
        run_move(6'd7, 6'd15, 1'b0, lat, v, b, bc);
        n_vec++; if (v !== 1'b1) begin n_err++; $display("FAIL king_step: got %b want 1", v); end
        run_move(6'd7, 6'd8, 1'b0, lat, v, b, bc);
        n_vec++; if (v !== 1'b0) begin n_err++; $display("FAIL king_nowrap: got %b want 0", v); end
        run_move(6'd7, 6'd7, 1'b0, lat, v, b, bc);
        n_vec++; if (v !== 1'b0 || lat != 2) begin
            n_err++; $display("FAIL same_square: got valid %b lat %0d want 0 lat 2", v, lat);
        end
        put(0, 4'h7);
        run_move(6'd0, 6'd1, 1'b0, lat, v, b, bc);
        n_vec++; if (v !== 1'b0) begin n_err++; $display("FAIL bad_code: got %b want 0", v); end
    endtask

    task automatic test_back_to_back();
        int lat, dones; logic v;
        passed_board = '0;
        put(63, 4'h5);
        @(negedge clk);
        src_address = 6'd63;
        dst_address = 6'd0;
        player      = 1'b0;
        req         = 1'b1;
        @(negedge clk);
        req   = 1'b0;
        lat   = -1;
        v     = 1'b0;
        dones = 0;
        for (int n = 0; n < 20; n++) begin
            req = (n == 1);
            if (done) begin
                dones++;
                if (lat < 0) begin lat = n; v = is_valid_move; end
            end
            @(negedge clk);
        end
        req = 1'b0;
        n_vec++; if (dones != 1) begin n_err++; $display("FAIL queen_dones: got %0d want 1", dones); end
        n_vec++; if (lat != (WALK_EN ? 8 : 2)) begin
            n_err++; $display("FAIL queen_lat: got %0d want %0d", lat, WALK_EN ? 8 : 2);
        end
        n_vec++; if (v !== 1'b1) begin n_err++; $display("FAIL queen_valid: got %b want 1", v); end
    endtask

    task automatic test_reset_mid_walk();
        int lat, bc; logic v, seen; logic [5:0] b;
        passed_board = '0;
        put(56, 4'h4);
        @(negedge clk);
        src_address = 6'd56;
        dst_address = 6'd32;
        player      = 1'b0;
        req         = 1'b1;
        @(negedge clk);
        req = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL midrst_busy: got %b want 0", busy); end
        n_vec++; if (done !== 1'b0) begin n_err++; $display("FAIL midrst_done: got %b want 0", done); end
        n_vec++; if (is_valid_move !== 1'b0) begin
            n_err++; $display("FAIL midrst_valid: got %b want 0", is_valid_move);
        end
        seen = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (done) seen = 1'b1;
        end
        rst = 1'b0;
        repeat (4) begin
            @(negedge clk);
            if (done) seen = 1'b1;
        end
        n_vec++; if (seen !== 1'b0) begin n_err++; $display("FAIL midrst_nodone: got %b want 0", seen); end
        run_move(6'd56, 6'd32, 1'b0, lat, v, b, bc);
        n_vec++; if (lat != (WALK_EN ? 4 : 2) || v !== 1'b1) begin
            n_err++;
            $display("FAIL after_rst: got lat %0d valid %b want lat %0d valid 1",
                     lat, v, WALK_EN ? 4 : 2);
        end
    endtask

    initial begin
        test_reset();
        test_rook_walk();
        test_pawn();
        test_knight();
        test_edges();
        test_back_to_back();
        test_reset_mid_walk();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
